vga_timing_gen: RTL and testbench

Raster timing generator feeding the text renderer in the VGA text path. Free-running horizontal/vertical counters emit pixel coordinates to the renderer. Sync and blanking are delayed so they realign with the renderer's pipelined colour output. The block then registers the final hsync, vsync and colour pins.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/sync_delay.sv | 34 +++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA text path.
package vga_pkg;

    // Default raster timing, in pixels (horizontal) and lines (vertical).
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int PIPE_DLY_DEF = 2;

    // Coordinates are 10 bits wide, so a period may not exceed 1024.
    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    // Per-pixel timing flags carried alongside the renderer pipeline.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } sync_bits_t;

    // Full period of one axis: visible + front porch + sync + back porch.
    function automatic int axisTotal(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Enable-gated shift register of sync_bits_t. Holds every stage when
// clk_en is low; reusable by any overlay layer that needs to realign its
// timing flags with a pipelined colour path.
module sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  sync_bits_t syncIn,
    output sync_bits_t syncOut
);

    sync_bits_t stage [DEPTH];

    // Shift the flags one stage per enabled cycle; clear all stages on reset.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (clk_en) begin
            stage[0] <= syncIn;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign syncOut = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator for the VGA text path. Free-running x/y counters
// feed the renderer; sync/blank flags travel through a delay line matching
// the renderer latency so the registered pins line up with its colour.
//
// clk_en is a pixel strobe, not a handshake: there is no back-pressure, and
// every register in this block advances only in cycles where clk_en is 1.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int PIPE_DLY = PIPE_DLY_DEF
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic       clk_en,
    output coord_t     x_coord,
    output coord_t     y_coord,
    output logic       frame_start,
    input  logic [2:0] pix_in,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       de,
    output logic [2:0] rgb
);

    localparam int H_TOTAL = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t COORD_ONE = coord_t'(1);

    // Sync windows as half-open integer ranges; int compares avoid the
    // 10-bit wrap when a window ends exactly at 1024.
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    // Refuse to build timings the counters or delay line cannot represent.
    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE_DLY must be 1..8");
    end

    coord_t     xCnt;
    coord_t     yCnt;
    sync_bits_t syncNow;
    sync_bits_t syncDly;
    int         xInt;
    int         yInt;

    // Raster counters: x wraps each line, y steps on the x wrap.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (clk_en) begin
            if (xCnt == H_LAST) begin
                xCnt <= '0;
                if (yCnt == V_LAST) begin
                    yCnt <= '0;
                end else begin
                    yCnt <= yCnt + COORD_ONE;
                end
            end else begin
                xCnt <= xCnt + COORD_ONE;
            end
        end
    end

    // Decode the current coordinate into active/sync flags.
    always_comb begin
        xInt        = int'(xCnt);
        yInt        = int'(yCnt);
        syncNow     = '0;
        syncNow.act = (xInt < H_ACTIVE) && (yInt < V_ACTIVE);
        syncNow.hs  = (xInt >= HS_START) && (xInt < HS_END);
        syncNow.vs  = (yInt >= VS_START) && (yInt < VS_END);
    end

    sync_delay #(
        .DEPTH (PIPE_DLY)
    ) u_sync_delay (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .syncIn  (syncNow),
        .syncOut (syncDly)
    );

    // Output pins: colour is masked by the delayed active flag so that
    // whatever the renderer drives during blanking never reaches rgb.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            de      <= 1'b0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            rgb     <= 3'b000;
        end else if (clk_en) begin
            de      <= syncDly.act;
            hsync_n <= ~syncDly.hs;
            vsync_n <= ~syncDly.vs;
            rgb     <= syncDly.act ? pix_in : 3'b000;
        end
    end

    assign x_coord     = xCnt;
    assign y_coord     = yCnt;
    // rst_n is included so the pulse stays low while the counters sit at
    // (0,0) in reset.
    assign frame_start = rst_n && clk_en && (xCnt == '0) && (yCnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced raster so several whole
// frames fit in a short run. Expected outputs come from a closed-form model
// indexed by the number of enabled cycles since reset release.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HA = 10;
    localparam int HF = 3;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int PD = 3;
    localparam int HT = HA + HF + HS + HB;   // 20
    localparam int VT = VA + VF + VS + VB;   // 12
    localparam int FT = HT * VT;             // 240

    logic       vga_clk = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clk_en  = 1'b0;
    logic [2:0] pix_in  = 3'b000;
    coord_t     x_coord;
    coord_t     y_coord;
    logic       frame_start;
    logic       hsync_n;
    logic       vsync_n;
    logic       de;
    logic [2:0] rgb;

    int     checks   = 0;
    int     failures = 0;
    int     nEn      = 0;   // enabled cycles since reset release
    int     hsLow    = 0;
    int     vsLow    = 0;
    int     fsSeen   = 0;
    int     xWraps   = 0;
    int     yWraps   = 0;
    coord_t prevX;
    coord_t prevY;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .PIPE_DLY (PD)
    ) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .x_coord     (x_coord),
        .y_coord     (y_coord),
        .frame_start (frame_start),
        .pix_in      (pix_in),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .de          (de),
        .rgb         (rgb)
    );

    // Clock
    always #5 vga_clk = ~vga_clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h nEn=%0d", tag, got, exp, nEn);
        end
    endtask

    // Compare every output with the model for the current cycle.
    task automatic check_outputs();
        int         p;
        int         px;
        int         py;
        logic       eAct;
        logic       eHs;
        logic       eVs;
        logic [2:0] eRgb;
        p    = nEn - PD - 1;
        px   = 0;
        eAct = 1'b0;
        eHs  = 1'b0;
        eVs  = 1'b0;
        if (rst_n && p >= 0) begin
            px   = p % HT;
            py   = (p / HT) % VT;
            eAct = (px < HA) && (py < VA);
            eHs  = (px >= HA + HF) && (px < HA + HF + HS);
            eVs  = (py >= VA + VF) && (py < VA + VF + VS);
        end
        eRgb = eAct ? px[2:0] : 3'b000;
        if (frame_start === 1'b1) fsSeen++;
        chk("x_coord", x_coord, coord_t'(nEn % HT));
        chk("y_coord", y_coord, coord_t'((nEn / HT) % VT));
        chk("frame_start", {9'd0, frame_start},
            {9'd0, (clk_en && rst_n && (nEn % FT == 0))});
        chk("de", {9'd0, de}, {9'd0, eAct});
        chk("hsync_n", {9'd0, hsync_n}, {9'd0, ~eHs});
        chk("vsync_n", {9'd0, vsync_n}, {9'd0, ~eVs});
        chk("rgb", {7'd0, rgb}, {7'd0, eRgb});
    endtask

    // Renderer stand-in: colour of pixel nEn-PD is its x[2:0]; X otherwise.
    task automatic drive_pix();
        int p;
        p = nEn - PD;
        if (clk_en && rst_n && p >= 0 && (p % HT) < HA && ((p / HT) % VT) < VA)
            pix_in = 3'((p % HT) & 7);
        else
            pix_in = 3'bxxx;
    endtask

    // Sync pulse widths counted on enabled cycles, per output line / frame.
    task automatic tally();
        int p;
        p = nEn - PD - 1;
        if (p >= 0) begin
            if (p % HT == 0) hsLow = 0;
            if (p % FT == 0) vsLow = 0;
            if (hsync_n === 1'b0) hsLow++;
            if (vsync_n === 1'b0) vsLow++;
            if (p % HT == HT - 1) chk("hsync_low_per_line", coord_t'(hsLow), coord_t'(HS));
            if (p % FT == FT - 1) chk("vsync_low_per_frame", coord_t'(vsLow), coord_t'(VS * HT));
        end
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic cycle(input logic en);
        clk_en = en;
        drive_pix();
        #1;
        check_outputs();
        if (en && rst_n) tally();
        @(posedge vga_clk);
        if (en && rst_n) nEn++;
        @(negedge vga_clk);
    endtask

    initial begin
        // Reset with clk_en high: frame_start must stay low.
        rst_n  = 1'b0;
        clk_en = 1'b1;
        @(negedge vga_clk);
        for (int i = 0; i < 3; i++) cycle(1'b1);

        // Release, then two full frames plus a few pixels, continuously enabled.
        rst_n  = 1'b1;
        nEn    = 0;
        fsSeen = 0;
        prevX  = '0;
        prevY  = '0;
        for (int i = 0; i < 2 * FT + 10; i++) begin
            cycle(1'b1);
            if (x_coord == '0 && prevX == coord_t'(HT - 1)) xWraps++;
            if (y_coord == '0 && prevY == coord_t'(VT - 1)) yWraps++;
            prevX = x_coord;
            prevY = y_coord;
        end
        chk("x_wraps", coord_t'(xWraps), coord_t'(24));
        chk("y_wraps", coord_t'(yWraps), coord_t'(2));
        chk("frame_start_pulses", coord_t'(fsSeen), coord_t'(3));

        // clk_en toggling 1,0 over a full frame of enabled cycles.
        for (int i = 0; i < 2 * FT; i++) cycle((i % 2) == 0);

        // Run to x=7,y=4, then reset between edges.
        while ((nEn % FT) != 4 * HT + 7) cycle(1'b1);
        clk_en = 1'b1;
        drive_pix();
        #2;
        rst_n = 1'b0;
        nEn   = 0;
        #1;
        check_outputs();
        @(posedge vga_clk);
        #1;
        check_outputs();
        @(negedge vga_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3 * HT; i++) cycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
